// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in the execute stage.
//   One quotient bit per cycle, signed or unsigned, result is {remainder, quotient}.
//   Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero_o output.
// Ports:
//   Clk, Rst_n    clock, synchronous active-low reset
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held until ready_o
//   annul_i       abort (pipeline flush)
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//   div_zero_o    (DIV_ZERO_FLAG_EN only) result came from a zero divisor
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,output logic               div_zero_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_dvd;    // dividend shifts out the top, quotient shifts in the bottom
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;

  logic [DATA_W-1:0] w_mag1, w_mag2;
  logic [DATA_W-1:0] w_diff;
  logic              w_borrow;

  // Magnitudes; the most negative value maps onto itself, which is already
  // the correct unsigned magnitude.
  assign w_mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Trial subtraction on {rem, next dividend bit}; when it does not borrow the
  // difference is below the divisor, so the low DATA_W bits hold it exactly.
  assign w_borrow = {r_rem, r_dvd[DATA_W-1]} < {1'b0, r_dvs};
  assign w_diff   = DATA_W'({r_rem, r_dvd[DATA_W-1]} - {1'b0, r_dvs});

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_o <= 1'b0;
`endif
    end else begin
      case (r_state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_o <= 1'b0;
`endif
          if (start_i && !annul_i) begin
            r_cnt <= '0;
            if (opdata2_i == '0) begin
              r_state <= BYZERO;
            end else begin
              r_state <= ON;
              r_dvd   <= w_mag1;
              r_dvs   <= w_mag2;
              r_rem   <= '0;
              r_neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_neg_r <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end
        end
        BYZERO: begin
          // Two cycles here so a zero divisor reports two edges after start.
          if (r_cnt == '0) begin
            r_cnt <= CNT_W'(1);
          end else begin
            r_state  <= END;
            result_o <= '0;
            ready_o  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b1;
`endif
          end
        end
        ON: begin
          if (annul_i) begin
            r_state  <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (r_cnt == CNT_W'(DATA_W)) begin
            r_state  <= END;
            ready_o  <= 1'b1;
            result_o <= {(r_neg_r ? -r_rem : r_rem), (r_neg_q ? -r_dvd : r_dvd)};
          end else begin
            r_dvd <= {r_dvd[DATA_W-2:0], ~w_borrow};
            r_rem <= w_borrow ? {r_rem[DATA_W-2:0], r_dvd[DATA_W-1]} : w_diff;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        END: begin
          // A held start keeps the result; only its release (or a flush) frees the unit.
          if (annul_i || !start_i) begin
            r_state  <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
          end
        end
        default: r_state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        Clk, Rst_n, signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif

  int tests = 0;
  int fails = 0;

  div_unit #(.DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero_o(div_zero_o)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: divide magnitudes, then apply DIV sign rules.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = (s && a[31]) ? 32'(0 - a) : a;
    mb = (s && b[31]) ? 32'(0 - b) : b;
    q = ma / mb;
    r = ma % mb;
    if (s && (a[31] ^ b[31])) q = 32'(0 - q);
    if (s && a[31]) r = 32'(0 - r);
    return {r, q};
  endfunction

  // Transaction-level model: a launched divide finishes a fixed number of
  // edges later (33 normally, 2 for a zero divisor) with the reference result.
  int          m_st = 0;      // 0 idle, 1 busy, 2 done
  int          m_left = 0;
  logic        m_zero = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_dz = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_pend = '0;

  always @(posedge Clk) begin
    if (!Rst_n) begin
      m_st = 0; m_ready = 1'b0; m_res = '0; m_dz = 1'b0; m_valid = 1'b1;
    end else begin
      case (m_st)
        0: if (start_i && !annul_i) begin
          m_zero = (opdata2_i == 32'd0);
          m_left = m_zero ? 2 : 33;
          m_pend = m_zero ? 64'd0 : ref_div(signed_div_i, opdata1_i, opdata2_i);
          m_st = 1;
        end
        1: if (annul_i && !m_zero) m_st = 0;
           else begin
             m_left--;
             if (m_left == 0) begin
               m_st = 2; m_ready = 1'b1; m_res = m_pend; m_dz = m_zero;
             end
           end
        default: if (annul_i || !start_i) begin
          m_st = 0; m_ready = 1'b0; m_res = '0; m_dz = 1'b0;
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("model_ready", 64'(ready_o), 64'(m_ready));
      chk("model_result", result_o, m_res);
`ifdef DIV_ZERO_FLAG_EN
      chk("model_div_zero", 64'(div_zero_o), 64'(m_dz));
`endif
    end
  end

  // Launch one divide, measure edges from the sampling edge to ready_o,
  // hold start in END for a few cycles, then release.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input string nm);
    int n;
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge Clk);
    #1;
    opdata1_i = 32'h1234_5678; opdata2_i = 32'd0;  // latched operands must be used
    n = 0;
    while (n < 100) begin
      @(posedge Clk); n++; #1;
      if (ready_o) break;
    end
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_result"}, result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
    chk({nm, "_dz"}, 64'(div_zero_o), 64'(b == 32'd0));
`endif
    repeat (3) @(posedge Clk);
    #1;
    chk({nm, "_held"}, {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    @(posedge Clk); #1;
    chk({nm, "_release"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    Rst_n = 1'b0; signed_div_i = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    do_div(1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                33, "u_100_7");
    do_div(1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "s_m7_2");
    do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0, 32'h8000_0000},        33, "s_min_m1");
    do_div(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0},        33, "u_min_max");
    do_div(1'b0, 32'd5,          32'd0,        64'd0,                           2, "u_by_zero");
    do_div(1'b1, 32'hFFFF_FFF9,  32'd0,        64'd0,                           2, "s_by_zero");
    do_div(1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},        33, "s_7_m2");
    do_div(1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0, 32'hFFFF_FFFF},         33, "u_max_1");
    do_div(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},       33, "s_m100_m7");
    do_div(1'b0, 32'd3,          32'd10,       {32'd3, 32'd0},                 33, "u_3_10");

    // annul with start in FREE: no launch
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    @(posedge Clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (40) @(posedge Clk);
    #1;
    chk("annul_free_no_result", {63'd0, ready_o}, 64'd0);

    // annul mid-divide, then a fresh divide
    opdata1_i = 32'd100; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge Clk);                       // E0
    repeat (9) @(posedge Clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge Clk); #1;                   // aborted here
    annul_i = 1'b0;
    repeat (30) @(posedge Clk);
    #1;
    chk("annul_on_no_result", {63'd0, ready_o}, 64'd0);
    do_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, "u_50_5_after_annul");

    // reset mid-divide discards the operation
    opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge Clk);                       // E0
    repeat (19) @(posedge Clk);
    #1;
    Rst_n = 1'b0; start_i = 1'b0;
    @(posedge Clk); #1;
    chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    Rst_n = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    chk("rst_mid_no_result", {63'd0, ready_o}, 64'd0);

    // annul while result is held in END frees the unit even with start high
    opdata1_i = 32'd77; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (36) @(posedge Clk);
    #1;
    chk("end_ready", {63'd0, ready_o}, 64'd1);
    chk("end_result", result_o, {32'd0, 32'd11});
    annul_i = 1'b1;
    @(posedge Clk); #1;
    chk("end_annul", {63'd0, ready_o}, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
